// File: rtl/downk.sv
// downk: K-way grouped majority unit with optional XNOR-weight learning.
//
// Forward: fin is padded to a whole number of K-bit units, XNORed with the
// weight register w and reduced by per-unit majority into fout.
// Backward: each unit's error bit bin[g] is XNORed with the unit's weights
// to produce bout.
//
// Build option: define DOWNK_WEIGHT_UPDATE_EN to compile in weight learning
// (toggle weights in BWD when oscillator is high). Without it, w is the
// constant all-ones and the block is a pure K-way majority.
module downk #(
   parameter int unsigned N = 27,
   parameter int unsigned K = 3,
   localparam int unsigned OUT_N = (N + K - 1) / K,
   localparam int unsigned PADDED_N = OUT_N * K,
   localparam int unsigned PADDING = PADDED_N - N
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                oscillator,
   input  logic                fd_prop,
   input  logic                bk_prop,
   input  logic [N-1:0]        fin,
   input  logic [OUT_N-1:0]    bin,
   output logic [OUT_N-1:0]    fout,
   output logic [N-1:0]        bout,
   output logic                fd_prop_done,
   output logic                bk_prop_done,
   output logic                busy,
   output logic [PADDED_N-1:0] control_out
);

   // Popcount width for one unit (K <= 8 fits in 4 bits).
   localparam int unsigned CNT_W = $clog2(K + 1);

   typedef enum logic [2:0] {
      StIdle,
      StFwd,
      StFwdOut,
      StBwd,
      StBwdOut
   } state_e;

   state_e state_q, state_d;

   // Datapath control decoded from the FSM state.
   logic latch_fwd;
   logic latch_bwd;
   logic do_fwd;
   logic do_bwd;

   logic [PADDED_N-1:0] p;
   logic [PADDED_N-1:0] p_q;
   logic [OUT_N-1:0]    bin_q;
   logic [PADDED_N-1:0] w;
   logic [PADDED_N-1:0] m;
   logic [OUT_N-1:0]    fout_d, fout_q;
   logic [N-1:0]        bout_d, bout_q;
   logic [CNT_W-1:0]    cnt;

   // ------------------------------------------------------------------
   // Input padding: pad bits alternate 1,0,1,... starting at bit N so a
   // partially filled top unit is biased neither fully on nor fully off.
   // ------------------------------------------------------------------
   assign p[N-1:0] = fin;

   for (genvar j = 0; j < PADDING; j++) begin : g_pad
      assign p[N+j] = ((j % 2) == 0) ? 1'b1 : 1'b0;
   end

   // ------------------------------------------------------------------
   // Weights
   // ------------------------------------------------------------------
`ifdef DOWNK_WEIGHT_UPDATE_EN
   logic [PADDED_N-1:0] w_q, w_d;
   logic [PADDED_N-1:0] w_flip;
   logic                upd_en;

   assign upd_en = do_bwd & oscillator;

   // Flip a real weight where its match bit disagrees with the unit error;
   // pad weights are held so the pad pattern keeps its meaning.
   for (genvar i = 0; i < PADDED_N; i++) begin : g_flip
      if (i < N) begin : g_real
         assign w_flip[i] = m[i] ^ bin_q[i/K];
      end else begin : g_padw
         assign w_flip[i] = 1'b0;
      end
   end

   // Next weight value: toggle selected bits in an enabled BWD cycle.
   always_comb begin
      w_d = w_q;
      if (upd_en) begin
         w_d = w_q ^ w_flip;
      end
   end

   // Weight register, all ones out of reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         w_q <= '1;
      end else begin
         w_q <= w_d;
      end
   end

   assign w = w_q;
`else
   logic unused_oscillator;

   assign unused_oscillator = oscillator;
   assign w = '1;
`endif

   assign control_out = w;

   // ------------------------------------------------------------------
   // Forward datapath
   // ------------------------------------------------------------------
   assign m = p_q ~^ w;

   // Per-unit majority; an exact tie (even K) falls back to the unit's low bit.
   always_comb begin
      fout_d = '0;
      cnt    = '0;
      for (int g = 0; g < OUT_N; g++) begin
         cnt = '0;
         for (int j = 0; j < K; j++) begin
            cnt = cnt + CNT_W'(m[g*K+j]);
         end
         if (cnt > CNT_W'(K / 2)) begin
            fout_d[g] = 1'b1;
         end else if (((K % 2) == 0) && (cnt == CNT_W'(K / 2))) begin
            fout_d[g] = m[g*K];
         end else begin
            fout_d[g] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Backward datapath: uses the weights as they stand before any update
   // made in the same cycle.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < N; i++) begin : g_bout
      assign bout_d[i] = bin_q[i/K] ~^ w[i];
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; forward wins over backward, requests outside IDLE drop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (fd_prop) begin
               state_d = StFwd;
            end else if (bk_prop) begin
               state_d = StBwd;
            end
         end
         StFwd:    state_d = StFwdOut;
         StFwdOut: state_d = StIdle;
         StBwd:    state_d = StBwdOut;
         StBwdOut: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Moore outputs and datapath strobes.
   always_comb begin
      latch_fwd    = 1'b0;
      latch_bwd    = 1'b0;
      do_fwd       = 1'b0;
      do_bwd       = 1'b0;
      fd_prop_done = 1'b0;
      bk_prop_done = 1'b0;
      busy         = 1'b1;
      case (state_q)
         StIdle: begin
            busy      = 1'b0;
            latch_fwd = fd_prop;
            latch_bwd = bk_prop & ~fd_prop;
         end
         StFwd:    do_fwd = 1'b1;
         StFwdOut: fd_prop_done = 1'b1;
         StBwd:    do_bwd = 1'b1;
         StBwdOut: bk_prop_done = 1'b1;
         default:  busy = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------

   // Operand latches and result registers; results hold until overwritten.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         p_q    <= '0;
         bin_q  <= '0;
         fout_q <= '0;
         bout_q <= '0;
      end else begin
         if (latch_fwd) begin
            p_q <= p;
         end
         if (latch_bwd) begin
            bin_q <= bin;
         end
         if (do_fwd) begin
            fout_q <= fout_d;
         end
         if (do_bwd) begin
            bout_q <= bout_d;
         end
      end
   end

   assign fout = fout_q;
   assign bout = bout_q;

   // ------------------------------------------------------------------
   // Sanity properties
   // ------------------------------------------------------------------
   a_done_onehot: assert property (@(posedge clk_in) disable iff (rst_in)
      !(fd_prop_done && bk_prop_done));

   a_done_busy: assert property (@(posedge clk_in) disable iff (rst_in)
      (fd_prop_done || bk_prop_done) |-> busy);

endmodule

// File: tb/tb_downk.sv
// Scoreboard bench for downk: three instances (27/3, 8/3, 4/2). Stimulus
// tasks push expected results; per-instance monitors pop on done pulses.
module tb_downk;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Instance 0: N=27, K=3
   logic        osc0, fd0, bk0;
   logic [26:0] fin0;
   logic [8:0]  bin0;
   logic [8:0]  fout0;
   logic [26:0] bout0;
   logic        fdd0, bkd0, busy0;
   logic [26:0] ctrl0;

   // Instance 1: N=8, K=3
   logic        osc1, fd1, bk1;
   logic [7:0]  fin1;
   logic [2:0]  bin1;
   logic [2:0]  fout1;
   logic [7:0]  bout1;
   logic        fdd1, bkd1, busy1;
   logic [8:0]  ctrl1;

   // Instance 2: N=4, K=2
   logic        osc2, fd2, bk2;
   logic [3:0]  fin2;
   logic [1:0]  bin2;
   logic [1:0]  fout2;
   logic [3:0]  bout2;
   logic        fdd2, bkd2, busy2;
   logic [3:0]  ctrl2;

   downk #(.N(27), .K(3)) dut0 (
      .clk_in(clk), .rst_in(rst), .oscillator(osc0), .fd_prop(fd0), .bk_prop(bk0),
      .fin(fin0), .bin(bin0), .fout(fout0), .bout(bout0), .fd_prop_done(fdd0),
      .bk_prop_done(bkd0), .busy(busy0), .control_out(ctrl0)
   );

   downk #(.N(8), .K(3)) dut1 (
      .clk_in(clk), .rst_in(rst), .oscillator(osc1), .fd_prop(fd1), .bk_prop(bk1),
      .fin(fin1), .bin(bin1), .fout(fout1), .bout(bout1), .fd_prop_done(fdd1),
      .bk_prop_done(bkd1), .busy(busy1), .control_out(ctrl1)
   );

   downk #(.N(4), .K(2)) dut2 (
      .clk_in(clk), .rst_in(rst), .oscillator(osc2), .fd_prop(fd2), .bk_prop(bk2),
      .fin(fin2), .bin(bin2), .fout(fout2), .bout(bout2), .fd_prop_done(fdd2),
      .bk_prop_done(bkd2), .busy(busy2), .control_out(ctrl2)
   );

   localparam logic [26:0] ONES27 = 27'h7FF_FFFF;
   localparam logic [26:0] MIX = 27'b011_000_111_010_101_001_110_100_011;  // -> 9'h155

`ifdef DOWNK_WEIGHT_UPDATE_EN
   localparam logic [26:0] W_LEARNT   = 27'h000_0000;
   localparam logic [26:0] BOUT_OSC0  = 27'h7FF_FFFF;
   localparam logic [8:0]  FOUT_AFTER = 9'h000;
   localparam logic [26:0] BOUT_F0    = 27'h700_0FFF;
`else
   localparam logic [26:0] W_LEARNT   = 27'h7FF_FFFF;
   localparam logic [26:0] BOUT_OSC0  = 27'h000_0000;
   localparam logic [8:0]  FOUT_AFTER = 9'h1FF;
   localparam logic [26:0] BOUT_F0    = 27'h0FF_F000;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0]  q_f0[$];
   logic [26:0] q_b0[$];
   logic [2:0]  q_f1[$];
   logic [1:0]  q_f2[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (fdd0) begin
         if (q_f0.size() == 0) check("dut0 fd_prop_done with nothing pending", 32'(fdd0), 0);
         else check("dut0 fout", 32'(fout0), 32'(q_f0.pop_front()));
      end
      if (bkd0) begin
         if (q_b0.size() == 0) check("dut0 bk_prop_done with nothing pending", 32'(bkd0), 0);
         else check("dut0 bout", 32'(bout0), 32'(q_b0.pop_front()));
      end
      if (fdd1) begin
         if (q_f1.size() == 0) check("dut1 fd_prop_done with nothing pending", 32'(fdd1), 0);
         else check("dut1 fout", 32'(fout1), 32'(q_f1.pop_front()));
      end
      if (fdd2) begin
         if (q_f2.size() == 0) check("dut2 fd_prop_done with nothing pending", 32'(fdd2), 0);
         else check("dut2 fout", 32'(fout2), 32'(q_f2.pop_front()));
      end
      if (bkd1 || bkd2) check("dut1/2 bk_prop_done never requested", 32'({bkd1, bkd2}), 0);
   end

   function automatic int pending();
      return q_f0.size() + q_b0.size() + q_f1.size() + q_f2.size();
   endfunction

   // Wait (bounded) for all expectations to be consumed, then idle two cycles.
   task automatic drain(input string name);
      int k = 0;
      while (pending() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({name, " completes within budget"}, 32'(pending()), 0);
      q_f0.delete();
      q_b0.delete();
      q_f1.delete();
      q_f2.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic fwd0(input logic [26:0] f, input logic [8:0] e);
      @(negedge clk);
      fin0 = f;
      fd0  = 1'b1;
      q_f0.push_back(e);
      @(negedge clk);
      fd0 = 1'b0;
   endtask

   task automatic bwd0(input logic [8:0] b, input logic o, input logic [26:0] e);
      @(negedge clk);
      bin0 = b;
      osc0 = o;
      bk0  = 1'b1;
      q_b0.push_back(e);
      @(negedge clk);
      bk0 = 1'b0;
   endtask

   task automatic fwd1(input logic [7:0] f, input logic [2:0] e);
      @(negedge clk);
      fin1 = f;
      fd1  = 1'b1;
      q_f1.push_back(e);
      @(negedge clk);
      fd1 = 1'b0;
   endtask

   task automatic fwd2(input logic [3:0] f, input logic [1:0] e);
      @(negedge clk);
      fin2 = f;
      fd2  = 1'b1;
      q_f2.push_back(e);
      @(negedge clk);
      fd2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      osc0 = 1'b0; fd0 = 1'b0; bk0 = 1'b0; fin0 = '0; bin0 = '0;
      osc1 = 1'b0; fd1 = 1'b0; bk1 = 1'b0; fin1 = '0; bin1 = '0;
      osc2 = 1'b0; fd2 = 1'b0; bk2 = 1'b0; fin2 = '0; bin2 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("reset fout0", 32'(fout0), 0);
      check("reset bout0", 32'(bout0), 0);
      check("reset done0", 32'({fdd0, bkd0}), 0);
      check("reset busy", 32'({busy0, busy1, busy2}), 0);
      check("reset control_out0", 32'(ctrl0), 32'(ONES27));
      check("reset control_out1", 32'(ctrl1), 32'h1FF);
      check("reset control_out2", 32'(ctrl2), 32'hF);

      // Backward before any forward pass
      bwd0(9'b101, 1'b0, 27'h000_01C7);
      drain("first bwd");

      // Forward latency and busy window
      @(negedge clk);
      fin0 = ONES27;
      fd0  = 1'b1;
      q_f0.push_back(9'h1FF);
      @(negedge clk);
      fd0 = 1'b0;
      check("t+1 busy", 32'(busy0), 1);
      check("t+1 fd_prop_done", 32'(fdd0), 0);
      @(negedge clk);
      check("t+2 busy", 32'(busy0), 1);
      check("t+2 fd_prop_done", 32'(fdd0), 1);
      @(negedge clk);
      check("t+3 busy", 32'(busy0), 0);
      check("t+3 fd_prop_done", 32'(fdd0), 0);
      check("fout holds", 32'(fout0), 32'h1FF);
      drain("latency fwd");

      fwd0(27'h0, 9'h000);
      drain("fwd zero");
      fwd0(27'h7, 9'h001);
      drain("fwd unit0");
      fwd0(MIX, 9'h155);
      drain("fwd mix");
      bwd0(9'h0F0, 1'b0, 27'h0FF_F000);
      drain("bwd 0F0");

      // Pulse during FWD_OUT is dropped, the next one in IDLE is taken
      @(negedge clk);
      fin0 = 27'h7;
      fd0  = 1'b1;
      q_f0.push_back(9'h001);
      @(negedge clk);
      fd0 = 1'b0;
      @(negedge clk);
      fin0 = ONES27;
      fd0  = 1'b1;
      @(negedge clk);
      fin0 = MIX;
      q_f0.push_back(9'h155);
      @(negedge clk);
      fd0 = 1'b0;
      drain("back-to-back");

      // Simultaneous fd/bk, then fd while busy: one forward done only
      @(negedge clk);
      fin0 = MIX;
      bin0 = 9'h1FF;
      fd0  = 1'b1;
      bk0  = 1'b1;
      q_f0.push_back(9'h155);
      @(negedge clk);
      bk0  = 1'b0;
      fin0 = ONES27;
      @(negedge clk);
      fd0 = 1'b0;
      drain("fd+bk collision");

      // Padded instance: unit 2 = {pad 1, fin[7], fin[6]}
      fwd1(8'hFF, 3'b111);
      drain("n8 ff");
      fwd1(8'h00, 3'b000);
      drain("n8 00");
      fwd1(8'hC0, 3'b100);
      drain("n8 c0");
      fwd1(8'h3F, 3'b011);
      drain("n8 3f");

      // Even K: a tie resolves to the low bit of each unit
      fwd2(4'b0110, 2'b10);
      drain("k2 0110");
      fwd2(4'b1001, 2'b01);
      drain("k2 1001");
      fwd2(4'b0111, 2'b11);
      drain("k2 0111");
      fwd2(4'b0000, 2'b00);
      drain("k2 0000");

      // Weight learning (constant weights when compiled out)
      fwd0(ONES27, 9'h1FF);
      drain("learn fwd");
      bwd0(9'h000, 1'b1, 27'h000_0000);
      drain("learn bwd osc1");
      osc0 = 1'b0;
      check("control_out after learn", 32'(ctrl0), 32'(W_LEARNT));
      bwd0(9'h000, 1'b0, BOUT_OSC0);
      drain("learn bwd osc0");
      check("control_out unchanged osc0", 32'(ctrl0), 32'(W_LEARNT));
      fwd0(ONES27, FOUT_AFTER);
      drain("fwd after learn");
      bwd0(9'h0F0, 1'b0, BOUT_F0);
      drain("bwd after learn");
      fwd0(27'h7, (W_LEARNT == '0) ? 9'h1FE : 9'h001);
      drain("fwd before abort");

      // Reset during FWD aborts the operation
      @(negedge clk);
      fin0 = ONES27;
      fd0  = 1'b1;
      @(negedge clk);
      fd0 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort fout0", 32'(fout0), 0);
      check("abort bout0", 32'(bout0), 0);
      check("abort done0", 32'({fdd0, bkd0}), 0);
      check("abort busy0", 32'(busy0), 0);
      check("abort control_out0", 32'(ctrl0), 32'(ONES27));
      repeat (3) @(negedge clk);
      fwd0(MIX, 9'h155);
      drain("fwd after abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
